// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared types and constants for the AXI write-channel arbiter
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  localparam int MAX_MST = 8;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam int D_ID_WIDTH   = 4;
  localparam int D_ADDR_WIDTH = 32;
  localparam int D_DATA_WIDTH = 32;

endpackage

// File: rtl/axi_rr_pick.sv
// rtl/axi_rr_pick.sv - combinational round-robin selector
// Returns the first asserted request at or after ptr, wrapping around.
module axi_rr_pick #(
  parameter int NUM_MST = 2,
  parameter int SEL_W   = $clog2(NUM_MST)
) (
  input  logic [NUM_MST-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   sel,
  output logic               any
);

  logic [SEL_W-1:0] w_idx [NUM_MST];

  always_comb begin
    for (int i = 0; i < NUM_MST; i++) begin
      w_idx[i] = SEL_W'((int'(ptr) + i) % NUM_MST);
    end
  end

  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (!any && req[w_idx[i]]) begin
        sel = w_idx[i];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_wr_arb.sv
// rtl/axi_wr_arb.sv - round-robin arbiter sharing one AXI write port among masters
// One transaction in flight; the granted master owns AW, W and B until the response.
module axi_wr_arb
  import axi_arb_pkg::*;
#(
  parameter int NUM_MST = 2,
  parameter int ID_W    = D_ID_WIDTH,
  parameter int ADDR_W  = D_ADDR_WIDTH,
  parameter int DATA_W  = D_DATA_WIDTH,
  localparam int GNT_W  = $clog2(NUM_MST)
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [NUM_MST-1:0][ID_W-1:0]      m_awid,
  input  logic [NUM_MST-1:0][ADDR_W-1:0]    m_awaddr,
  input  logic [NUM_MST-1:0][7:0]           m_awlen,
  input  logic [NUM_MST-1:0][2:0]           m_awsize,
  input  logic [NUM_MST-1:0][1:0]           m_awburst,
  input  logic [NUM_MST-1:0][2:0]           m_awprot,
  input  logic [NUM_MST-1:0]                m_awvalid,
  output logic [NUM_MST-1:0]                m_awready,
  input  logic [NUM_MST-1:0][ID_W-1:0]      m_wid,
  input  logic [NUM_MST-1:0][DATA_W-1:0]    m_wdata,
  input  logic [NUM_MST-1:0][DATA_W/8-1:0]  m_wstrb,
  input  logic [NUM_MST-1:0]                m_wlast,
  input  logic [NUM_MST-1:0]                m_wvalid,
  output logic [NUM_MST-1:0]                m_wready,
  output logic [NUM_MST-1:0][ID_W-1:0]      m_bid,
  output logic [NUM_MST-1:0][1:0]           m_bresp,
  output logic [NUM_MST-1:0]                m_bvalid,
  input  logic [NUM_MST-1:0]                m_bready,
  output logic [ID_W-1:0]                   s_awid,
  output logic [ADDR_W-1:0]                 s_awaddr,
  output logic [7:0]                        s_awlen,
  output logic [2:0]                        s_awsize,
  output logic [1:0]                        s_awburst,
  output logic [2:0]                        s_awprot,
  output logic                              s_awvalid,
  input  logic                              s_awready,
  output logic [ID_W-1:0]                   s_wid,
  output logic [DATA_W-1:0]                 s_wdata,
  output logic [DATA_W/8-1:0]               s_wstrb,
  output logic                              s_wlast,
  output logic                              s_wvalid,
  input  logic                              s_wready,
  input  logic [ID_W-1:0]                   s_bid,
  input  logic [1:0]                        s_bresp,
  input  logic                              s_bvalid,
  output logic                              s_bready,
  output logic [GNT_W-1:0]                  grant,
  output logic                              len_err
);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [GNT_W-1:0] r_grant;
  logic [GNT_W-1:0] r_rr_ptr;
  logic [GNT_W-1:0] w_ptr_nxt;
  logic [GNT_W-1:0] w_pick_sel;
  logic             w_pick_any;
  logic [7:0]       r_awlen_q;
  logic [7:0]       r_beat_cnt;
  logic             r_len_err;
  logic             w_len_err_nxt;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_b_hs;

  axi_rr_pick #(
    .NUM_MST (NUM_MST),
    .SEL_W   (GNT_W)
  ) u_pick (
    .req (m_awvalid),
    .ptr (r_rr_ptr),
    .sel (w_pick_sel),
    .any (w_pick_any)
  );

  assign w_aw_hs   = s_awvalid && s_awready;
  assign w_w_hs    = s_wvalid && s_wready;
  assign w_b_hs    = s_bvalid && s_bready;
  assign w_ptr_nxt = (r_grant == GNT_W'(NUM_MST - 1)) ? '0 : r_grant + GNT_W'(1);

  // Both a short burst (early WLAST) and an overrun (no WLAST on the last
  // expected beat) are flagged; the burst still ends only on WLAST.
  assign w_len_err_nxt = w_w_hs &&
                         (s_wlast ? (r_beat_cnt != r_awlen_q) : (r_beat_cnt == r_awlen_q));

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_any)         w_state_nxt = ADDR;
      ADDR:    if (w_aw_hs)            w_state_nxt = DATA;
      DATA:    if (w_w_hs && s_wlast)  w_state_nxt = RESP;
      RESP:    if (w_b_hs)             w_state_nxt = IDLE;
      default:                         w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_awlen_q  <= '0;
      r_beat_cnt <= '0;
      r_len_err  <= 1'b0;
    end else begin
      r_len_err <= w_len_err_nxt;
      if (r_state == IDLE && w_pick_any) begin
        r_grant <= w_pick_sel;
      end
      if (w_aw_hs) begin
        r_awlen_q  <= s_awlen;
        r_beat_cnt <= '0;
      end else if (w_w_hs) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end
      if (w_b_hs) begin
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  // Payloads follow the grant unconditionally; only valids/readies are gated.
  always_comb begin
    s_awid    = m_awid[r_grant];
    s_awaddr  = m_awaddr[r_grant];
    s_awlen   = m_awlen[r_grant];
    s_awsize  = m_awsize[r_grant];
    s_awburst = m_awburst[r_grant];
    s_awprot  = m_awprot[r_grant];
    s_wid     = m_wid[r_grant];
    s_wdata   = m_wdata[r_grant];
    s_wstrb   = m_wstrb[r_grant];
    s_wlast   = m_wlast[r_grant];
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    case (r_state)
      ADDR: begin
        s_awvalid          = m_awvalid[r_grant];
        m_awready[r_grant] = s_awready;
      end
      DATA: begin
        s_wvalid          = m_wvalid[r_grant];
        m_wready[r_grant] = s_wready;
      end
      RESP: begin
        s_bready          = m_bready[r_grant];
        m_bvalid[r_grant] = s_bvalid;
      end
      default: ;
    endcase
  end

  assign m_bid   = {NUM_MST{s_bid}};
  assign m_bresp = {NUM_MST{s_bresp}};
  assign grant   = r_grant;
  assign len_err = r_len_err;

endmodule

// File: tb/tb_axi_wr_arb.sv
// tb/tb_axi_wr_arb.sv - self-checking bench for axi_wr_arb
module tb_axi_wr_arb;
  import axi_arb_pkg::*;

  localparam int NM  = 2;
  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  logic [NM-1:0][IDW-1:0]  m_awid;
  logic [NM-1:0][AW-1:0]   m_awaddr;
  logic [NM-1:0][7:0]      m_awlen;
  logic [NM-1:0][2:0]      m_awsize;
  logic [NM-1:0][1:0]      m_awburst;
  logic [NM-1:0][2:0]      m_awprot;
  logic [NM-1:0]           m_awvalid, m_awready;
  logic [NM-1:0][IDW-1:0]  m_wid;
  logic [NM-1:0][DW-1:0]   m_wdata;
  logic [NM-1:0][DW/8-1:0] m_wstrb;
  logic [NM-1:0]           m_wlast, m_wvalid, m_wready;
  logic [NM-1:0][IDW-1:0]  m_bid;
  logic [NM-1:0][1:0]      m_bresp;
  logic [NM-1:0]           m_bvalid, m_bready;
  logic [IDW-1:0]          s_awid, s_wid, s_bid;
  logic [AW-1:0]           s_awaddr;
  logic [7:0]              s_awlen;
  logic [2:0]              s_awsize, s_awprot;
  logic [1:0]              s_awburst, s_bresp;
  logic                    s_awvalid, s_awready;
  logic [DW-1:0]           s_wdata;
  logic [DW/8-1:0]         s_wstrb;
  logic                    s_wlast, s_wvalid, s_wready;
  logic                    s_bvalid, s_bready;
  logic [0:0]              grant;
  logic                    len_err;

  axi_wr_arb #(.NUM_MST(NM), .ID_W(IDW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .grant(grant), .len_err(len_err)
  );

  typedef struct {
    logic [NM-1:0] mask;
    int            alen;
    int            nb;
    bit            early;
    logic [1:0]    resp;
    int            first;
    int            errs;
  } vec_t;
  vec_t vecs[6];

  int checks = 0;
  int errors = 0;

  // master agents
  int ph[NM];
  int alen[NM];
  int nb[NM];
  int bi[NM];
  int jobn[NM];
  bit early[NM];
  // slave agent
  bit         rnd_slave;
  bit         bpend;
  int         bdelay;
  logic [1:0] sresp;
  logic [1:0] vresp;
  logic [IDW-1:0] sbid;
  bit         rst_req;
  // reference model: ownership, round-robin pointer, beat count
  bit   busy;
  int   g;
  int   ptr;
  bit   aw_done, w_done;
  int   mbeat;
  logic exp_le;
  int   vec_first, vec_errs;

  function automatic logic [DW-1:0] pat(input int m, input int j, input int b);
    return DW'(((m & 255) << 24) | ((j & 255) << 16) | (b & 65535));
  endfunction

  function automatic int pick(input int p, input logic [NM-1:0] req);
    for (int k = 0; k < NM; k++) if (req[(p + k) % NM]) return (p + k) % NM;
    return -1;
  endfunction

  function automatic bit all_idle();
    bit r;
    r = !busy && !bpend;
    for (int m = 0; m < NM; m++) if (ph[m] != 0) r = 0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_job(input int m, input int al, input int n, input bit e);
    ph[m] = 1; alen[m] = al; nb[m] = n; bi[m] = 0; early[m] = e;
  endtask

  task automatic drive();
    ARESET = rst_req;
    for (int m = 0; m < NM; m++) begin
      m_awvalid[m] = (ph[m] == 1);
      m_awid[m]    = IDW'(m);
      m_awaddr[m]  = AW'(32'h1000 * (m + 1) + jobn[m]);
      m_awlen[m]   = 8'(alen[m]);
      m_awsize[m]  = 3'd2;
      m_awburst[m] = 2'b01;
      m_awprot[m]  = 3'd0;
      m_wvalid[m]  = (ph[m] == 2) || (ph[m] == 1 && early[m]);
      m_wid[m]     = IDW'(m);
      m_wdata[m]   = pat(m, jobn[m], bi[m]);
      m_wstrb[m]   = '1;
      m_wlast[m]   = (bi[m] == nb[m] - 1);
      m_bready[m]  = rnd_slave ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    s_awready = rnd_slave ? 1'($urandom_range(0, 1)) : 1'b1;
    s_wready  = rnd_slave ? 1'($urandom_range(0, 1)) : 1'b1;
    s_bvalid  = bpend && (bdelay == 0);
    s_bresp   = sresp;
    s_bid     = sbid;
  endtask

  task automatic sample();
    logic [NM-1:0] ea, ew, eb;
    bit busy_pre, last;
    if (ARESET) begin
      busy = 0; ptr = 0; exp_le = 0; aw_done = 0; w_done = 0; bpend = 0; bdelay = 0;
      for (int m = 0; m < NM; m++) begin ph[m] = 0; bi[m] = 0; end
      return;
    end
    busy_pre = busy;
    if (bpend && bdelay > 0) bdelay--;
    ea = '0; ew = '0; eb = '0;
    if (busy) begin
      if (!aw_done)     ea[g] = s_awready;
      else if (!w_done) ew[g] = s_wready;
      else              eb[g] = s_bvalid;
    end
    chk("m_awready", m_awready, ea);
    chk("m_wready", m_wready, ew);
    chk("m_bvalid", m_bvalid, eb);
    chk("s_awvalid", s_awvalid, busy && !aw_done);
    chk("s_wvalid", s_wvalid, busy && aw_done && !w_done);
    chk("s_bready", s_bready, busy && w_done && m_bready[g]);
    if (busy) chk("grant", grant, g);
    chk("len_err", len_err, exp_le);
    if (len_err) vec_errs++;
    exp_le = 0;
    if (busy && !aw_done && s_awvalid && s_awready) begin
      chk("s_awid", s_awid, g);
      chk("s_awlen", s_awlen, alen[g]);
      if (vec_first < 0) vec_first = int'(grant);
      aw_done = 1; mbeat = 0;
    end else if (busy && aw_done && !w_done && s_wvalid && s_wready) begin
      last = (mbeat == nb[g] - 1);
      chk("s_wdata", s_wdata, pat(g, jobn[g], mbeat));
      chk("s_wlast", s_wlast, last);
      exp_le = last ? (mbeat != alen[g]) : (mbeat == alen[g]);
      mbeat++;
      if (last) begin
        chk("s_wid", s_wid, g);
        w_done = 1; bpend = 1; sbid = s_wid;
        bdelay = rnd_slave ? $urandom_range(0, 3) : 0;
        sresp  = rnd_slave ? ($urandom_range(0, 1) ? SLVERR : OKAY) : vresp;
      end
    end else if (busy && w_done && s_bvalid && s_bready) begin
      chk("m_bresp", m_bresp[g], sresp);
      chk("m_bid", m_bid[g], g);
      busy = 0; ptr = (g + 1) % NM; bpend = 0;
    end
    for (int m = 0; m < NM; m++) begin
      if (ph[m] == 1 && m_awvalid[m] && m_awready[m]) ph[m] = 2;
      else if (ph[m] == 2 && m_wvalid[m] && m_wready[m]) begin
        if (m_wlast[m]) ph[m] = 3;
        bi[m]++;
      end else if (ph[m] == 3 && m_bvalid[m] && m_bready[m]) begin
        ph[m] = 0; jobn[m]++;
      end
    end
    if (!busy_pre && (|m_awvalid)) begin
      g = pick(ptr, m_awvalid); busy = 1; aw_done = 0; w_done = 0;
    end
  endtask

  task automatic cycle();
    @(posedge ACLK); #1;
    drive();
    @(negedge ACLK);
    sample();
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int n = 0;
    while (!all_idle() && n < budget) begin cycle(); n++; end
    checks++;
    if (!all_idle()) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_len_err"}, len_err, 0);
    chk({tag, "_s_awvalid"}, s_awvalid, 0);
    chk({tag, "_s_wvalid"}, s_wvalid, 0);
    chk({tag, "_s_bready"}, s_bready, 0);
    chk({tag, "_m_rdyvld"}, {m_awready, m_wready, m_bvalid}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, al, nbt;
    vecs[0] = '{2'b11, 0, 1, 1'b0, OKAY,   0, 0};
    vecs[1] = '{2'b01, 3, 4, 1'b0, OKAY,   0, 0};
    vecs[2] = '{2'b01, 1, 1, 1'b0, SLVERR, 0, 1};
    vecs[3] = '{2'b01, 0, 2, 1'b0, OKAY,   0, 2};
    vecs[4] = '{2'b10, 0, 1, 1'b0, SLVERR, 1, 0};
    vecs[5] = '{2'b11, 2, 3, 1'b1, OKAY,   0, 0};
    rnd_slave = 0; bpend = 0; bdelay = 0; sresp = OKAY; vresp = OKAY; sbid = '0;
    busy = 0; g = 0; ptr = 0; aw_done = 0; w_done = 0; mbeat = 0; exp_le = 0;
    vec_first = -1; vec_errs = 0;
    for (int m = 0; m < NM; m++) begin
      ph[m] = 0; alen[m] = 0; nb[m] = 0; bi[m] = 0; jobn[m] = 0; early[m] = 0;
    end
    rst_req = 1;
    drive();
    cycle(); cycle();
    rst_req = 0;
    cycle();
    chk_quiet("reset");

    for (int v = 0; v < 6; v++) begin
      vresp = vecs[v].resp; vec_first = -1; vec_errs = 0;
      for (int m = 0; m < NM; m++)
        if (vecs[v].mask[m]) start_job(m, vecs[v].alen, vecs[v].nb, vecs[v].early);
      run_until_idle(200, "vec_done");
      chk($sformatf("vec%0d_first_grant", v), vec_first, vecs[v].first);
      chk($sformatf("vec%0d_len_err_pulses", v), vec_errs, vecs[v].errs);
    end

    // abandon a burst mid-DATA; rr pointer is 1 beforehand so a fresh grant goes to 0
    vresp = OKAY;
    start_job(0, 0, 1, 0);
    run_until_idle(50, "pre_reset_job");
    start_job(1, 3, 4, 0);
    n = 0;
    while (!(busy && g == 1 && aw_done && mbeat == 2) && n < 50) begin cycle(); n++; end
    chk("reach_beat2", n < 50, 1);
    rst_req = 1; cycle();
    rst_req = 0; cycle();
    chk_quiet("midrst");
    vec_first = -1;
    start_job(0, 1, 2, 0); start_job(1, 1, 2, 0);
    run_until_idle(100, "post_reset");
    chk("post_reset_first_grant", vec_first, 0);

    rnd_slave = 1;
    for (int c = 0; c < 1500; c++) begin
      for (int m = 0; m < NM; m++) begin
        if (ph[m] == 0 && $urandom_range(0, 3) == 0) begin
          al  = $urandom_range(0, 4);
          nbt = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : al + 1;
          start_job(m, al, nbt, 1'($urandom_range(0, 1)));
        end
      end
      cycle();
    end
    run_until_idle(400, "drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
